// File: rtl/handshake_sync_pkg.sv
// Shared constants, state encodings and helpers for the handshake_sync word resynchronizer.
package handshake_sync_pkg;

   localparam int MODE_2PHASE = 0;
   localparam int MODE_4PHASE = 1;

   typedef enum logic [1:0] {
      A_IDLE = 2'd0,
      A_REQ  = 2'd1,
      A_DROP = 2'd2
   } a_state_e;

   typedef enum logic [1:0] {
      B_IDLE  = 2'd0,
      B_HOLD  = 2'd1,
      B_ACKED = 2'd2
   } b_state_e;

   // 2-phase: any change of the request since the last load is new; 4-phase: the level itself.
   function automatic logic req_is_new(input logic four_phase, input logic req_sync, input logic req_seen);
      if (four_phase) begin
         return req_sync;
      end else begin
         return req_sync ^ req_seen;
      end
   endfunction

endpackage

// File: rtl/handshake_sync_sync_bit.sv
// Single-bit synchronizer chain, advanced only on the receiving side's enable strobe.
module handshake_sync_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ce,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] chain_q;

   // Shift chain, one stage per receiving-side strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_q <= '0;
      end else if (ce) begin
         chain_q <= {chain_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/handshake_sync.sv
// Ready/valid word resynchronizer between two strobe domains of one clock, using a
// 2-phase or 4-phase req/ack handshake around a stable hold register.
module handshake_sync
   import handshake_sync_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int MODE        = MODE_2PHASE,
   parameter int DROP_W      = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_ce,
   input  logic              b_ce,
   input  logic              a_valid,
   input  logic [WIDTH-1:0]  a_data,
   output logic              a_ready,
   output logic              b_valid,
   output logic [WIDTH-1:0]  b_data,
   input  logic              b_ready,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam logic FOUR_PH = (MODE == MODE_4PHASE);

   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      if (&v) begin
         return v;
      end else begin
         return v + {{(DROP_W-1){1'b0}}, 1'b1};
      end
   endfunction

   a_state_e           a_state_q, a_state_d;
   logic               a_ready_q;
   logic               req_q, req_d;
   logic [WIDTH-1:0]   hold_q, hold_d;
   logic [DROP_W-1:0]  drop_q, drop_d;
   logic               ack_sync_s;

   b_state_e           b_state_q, b_state_d;
   logic               ack_q, ack_d;
   logic               b_valid_q, b_valid_d;
   logic [WIDTH-1:0]   b_data_q, b_data_d;
   logic               seen_q, seen_d;
   logic               req_sync_s;

   handshake_sync_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (b_ce),
      .d_i   (req_q),
      .q_o   (req_sync_s)
   );

   handshake_sync_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (a_ce),
      .d_i   (ack_q),
      .q_o   (ack_sync_s)
   );

   // Source-side registers; a_ready is registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_state_q <= A_IDLE;
         a_ready_q <= 1'b1;
         req_q     <= 1'b0;
         hold_q    <= '0;
         drop_q    <= '0;
      end else if (a_ce) begin
         a_state_q <= a_state_d;
         a_ready_q <= (a_state_d == A_IDLE);
         req_q     <= req_d;
         hold_q    <= hold_d;
         drop_q    <= drop_d;
      end
   end

   // Source next state.
   always_comb begin
      a_state_d = a_state_q;
      case (a_state_q)
         A_IDLE: begin
            if (a_valid) a_state_d = A_REQ;
            else         a_state_d = A_IDLE;
         end
         A_REQ: begin
            if (FOUR_PH) begin
               if (ack_sync_s) a_state_d = A_DROP;
               else            a_state_d = A_REQ;
            end else begin
               if (ack_sync_s == req_q) a_state_d = A_IDLE;
               else                     a_state_d = A_REQ;
            end
         end
         A_DROP: begin
            if (!ack_sync_s) a_state_d = A_IDLE;
            else             a_state_d = A_DROP;
         end
         default: a_state_d = A_IDLE;
      endcase
   end

   // Source datapath: capture/request, request release, drop counting.
   always_comb begin
      req_d  = req_q;
      hold_d = hold_q;
      drop_d = drop_q;
      if (a_valid && !a_ready_q) begin
         drop_d = sat_inc(drop_q);
      end else begin
         drop_d = drop_q;
      end
      case (a_state_q)
         A_IDLE: begin
            if (a_valid) begin
               hold_d = a_data;
               req_d  = FOUR_PH ? 1'b1 : ~req_q;
            end else begin
               hold_d = hold_q;
            end
         end
         A_REQ: begin
            if (FOUR_PH && ack_sync_s) req_d = 1'b0;
            else                       req_d = req_q;
         end
         default: req_d = req_q;
      endcase
   end

   // Destination-side registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_state_q <= B_IDLE;
         ack_q     <= 1'b0;
         b_valid_q <= 1'b0;
         b_data_q  <= '0;
         seen_q    <= 1'b0;
      end else if (b_ce) begin
         b_state_q <= b_state_d;
         ack_q     <= ack_d;
         b_valid_q <= b_valid_d;
         b_data_q  <= b_data_d;
         seen_q    <= seen_d;
      end
   end

   // Destination next state.
   always_comb begin
      b_state_d = b_state_q;
      case (b_state_q)
         B_IDLE: begin
            if (req_is_new(FOUR_PH, req_sync_s, seen_q)) b_state_d = B_HOLD;
            else                                         b_state_d = B_IDLE;
         end
         B_HOLD: begin
            if (b_ready) b_state_d = FOUR_PH ? B_ACKED : B_IDLE;
            else         b_state_d = B_HOLD;
         end
         B_ACKED: begin
            if (!req_sync_s) b_state_d = B_IDLE;
            else             b_state_d = B_ACKED;
         end
         default: b_state_d = B_IDLE;
      endcase
   end

   // Destination datapath: the hold register is only sampled once the request is seen.
   always_comb begin
      ack_d     = ack_q;
      b_valid_d = b_valid_q;
      b_data_d  = b_data_q;
      seen_d    = seen_q;
      case (b_state_q)
         B_IDLE: begin
            if (req_is_new(FOUR_PH, req_sync_s, seen_q)) begin
               b_data_d  = hold_q;
               b_valid_d = 1'b1;
               seen_d    = req_sync_s;
            end else begin
               b_valid_d = 1'b0;
            end
         end
         B_HOLD: begin
            if (b_ready) begin
               b_valid_d = 1'b0;
               ack_d     = FOUR_PH ? 1'b1 : ~ack_q;
            end else begin
               b_valid_d = 1'b1;
            end
         end
         B_ACKED: begin
            if (!req_sync_s) ack_d = 1'b0;
            else             ack_d = ack_q;
         end
         default: b_valid_d = 1'b0;
      endcase
   end

   assign a_ready  = a_ready_q;
   assign b_valid  = b_valid_q;
   assign b_data   = b_data_q;
   assign drop_cnt = drop_q;

endmodule
